hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage CPU (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers in a 3-entry scoreboard (EX, MEM, WB).
- Detects read-after-write hazards for the instruction in ID and stalls the front end.
- Freezes fetch after a branch/jump until the MEM stage resolves it, then redirects or resumes.

Parameters:
RESOLVE_TIMEOUT, 8, maximum cycles in CTRL_WAIT before the error abort.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > RESOLVE_TIMEOUT.

Ports:
clk  in  1  clock, rising edge
arst  in  1  asynchronous reset, active-high
enable  in  1  global run; 0 freezes all state and outputs
id_valid  in  1  ID stage holds a real instruction
id_rs  in  5  ID source register 1
id_rt  in  5  ID source register 2
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_reg_write  in  1  ID instruction writes a register
id_waddr  in  5  ID destination register (after RegDst select)
id_mem_read  in  1  ID instruction is a load
id_ctrl  in  1  ID instruction is a branch or jump
br_resolve  in  1  one-cycle pulse from MEM: branch/jump outcome valid
br_taken  in  1  outcome; jumps always report 1
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_bubble  out  1  zero control fields entering ID/EX
redirect  out  1  PC loads branch/jump target this cycle
fwd_a  out  2  rs forward select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB bypass
fwd_b  out  2  rt forward select, same encoding
ctrl_err  out  1  sticky flag: resolve timeout occurred
state  out  2  00 RUN, 01 CTRL_WAIT

Behaviour:
- Reset (async): state=RUN, scoreboard invalid, counter=0, ctrl_err=0.
  - Reset-value outputs: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=0, redirect=0, fwd_a/fwd_b=00.
- Scoreboard entries hold {valid, waddr, is_load}.
  - valid = id_reg_write && id_waddr!=0; writes to register 0 never create entries.
  - Each enable cycle, entries shift EX->MEM->WB; the WB entry is discarded.
  - EX receives the ID entry on issue, otherwise an invalid entry.
- issue = enable && id_valid && state==RUN && !stall.
- Hazard match: a valid entry has waddr==id_rs while id_use_rs, or waddr==id_rt while id_use_rt.
- Stall rule, base build: stall if any of EX/MEM/WB matches. The register file has no write-through, so a WB match stalls.
- During stall: pc_en=0, if_id_en=0, id_ex_bubble=1. The ID instruction stays in ID and re-evaluates next cycle.
- RUN -> CTRL_WAIT when issue && id_ctrl.
  - In that same cycle: pc_en=0, if_id_flush=1, counter cleared.
- CTRL_WAIT: pc_en=0, if_id_flush=1, id_ex_bubble=1; counter increments each enable cycle.
- In CTRL_WAIT with br_resolve=1: return to RUN.
  - Both outcomes: pc_en=1, if_id_flush=0, if_id_en=1 this cycle.
  - redirect=br_taken.
- CTRL_WAIT with counter==RESOLVE_TIMEOUT and no br_resolve: set ctrl_err, return to RUN, redirect=0.
- br_resolve while in RUN: ignored.
- Stall and CTRL_WAIT are exclusive; stall is evaluated only in RUN.
- enable=0: no state, counter or scoreboard change.
  - pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=0, redirect=0.
- Outputs are combinational from state, scoreboard and inputs. fwd_a/fwd_b are combinational for the ID instruction and are meant to be registered into ID/EX.

Optional Feature:
FORWARDING_EN
- Defined: stall only when the EX entry matches and is_load (load-use, exactly 1 bubble).
- Defined, forward select per operand: youngest match wins.
  - EX match -> 01.
  - MEM match -> 10.
  - WB match -> 11, where the datapath muxes regfile_wdata into ID/EX.
- Not defined: fwd_a=fwd_b=00 always, and the base stall rule applies.

Test Plan:
1. Reset: arst=1 mid-CTRL_WAIT -> state=00, pc_en=1, ctrl_err=0, scoreboard cleared; the next independent ID instruction issues without stall.
2. Base build: EX entry waddr=5, ID id_rs=5 with id_use_rs=1 -> stall for 3 cycles (pc_en=0, id_ex_bubble=1), issue on the 4th cycle.
3. id_reg_write=1, id_waddr=0, followed by a consumer of r0 -> no stall.
4. FORWARDING_EN: load to r7 in EX, ID reads r7 -> one bubble, then fwd_a=10 at issue. A non-load in EX matching rt gives fwd_b=01 with no stall.
5. Branch issues, br_resolve with br_taken=1 three cycles later -> if_id_flush=1 for 3 cycles, then redirect=1 and pc_en=1 for one cycle, state=RUN.
6. Branch issues, no resolve for RESOLVE_TIMEOUT=8 cycles -> ctrl_err=1 (sticky), state=RUN, redirect=0. A later br_resolve in RUN has no effect.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard controller for a 5-stage pipeline: RAW scoreboard stalls plus branch/jump fetch freeze.
// Optional FORWARDING_EN: stall only on load-use and drive fwd_a/fwd_b forwarding selects.
module hazard_controller #(
    parameter int RESOLVE_TIMEOUT = 8,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       enable,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_reg_write,
    input  logic [4:0] id_waddr,
    input  logic       id_mem_read,
    input  logic       id_ctrl,
    input  logic       br_resolve,
    input  logic       br_taken,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       redirect,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       ctrl_err,
    output logic [1:0] state
);
    localparam logic [1:0]       RUN       = 2'b00;
    localparam logic [1:0]       CTRL_WAIT = 2'b01;
    localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(RESOLVE_TIMEOUT);

    // Scoreboard index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]      sb_valid_r;
    logic [2:0][4:0] sb_waddr_r;
    logic [2:0]      sb_load_r;

    logic [1:0]       state_r, state_n_s;
    logic [CNT_W-1:0] cnt_r, cnt_n_s;
    logic             err_r, err_n_s;
    logic [2:0]       hit_a_s, hit_b_s;
    logic             stall_s, issue_s;
    logic             unused_s;

    function automatic logic src_hit(input logic v, input logic [4:0] waddr,
                                     input logic [4:0] src, input logic use_src);
        return v && use_src && (waddr == src);
    endfunction

`ifdef FORWARDING_EN
    // Youngest matching stage wins the forward select.
    function automatic logic [1:0] fwd_sel(input logic [2:0] hit);
        logic [1:0] sel;
        if (hit[0]) begin
            sel = 2'b01;
        end else if (hit[1]) begin
            sel = 2'b10;
        end else if (hit[2]) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction
`endif

    // Per-stage source-operand match against the ID instruction.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hit_a_s[i] = src_hit(sb_valid_r[i], sb_waddr_r[i], id_rs, id_use_rs);
            hit_b_s[i] = src_hit(sb_valid_r[i], sb_waddr_r[i], id_rt, id_use_rt);
        end
    end

    // Stall decision and forward selects for the ID instruction.
    always_comb begin
`ifdef FORWARDING_EN
        stall_s = (state_r == RUN) && id_valid && (hit_a_s[0] || hit_b_s[0]) && sb_load_r[0];
        fwd_a   = fwd_sel(hit_a_s);
        fwd_b   = fwd_sel(hit_b_s);
`else
        stall_s = (state_r == RUN) && id_valid && ((|hit_a_s) || (|hit_b_s));
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
`endif
        issue_s = enable && id_valid && (state_r == RUN) && !stall_s;
    end

    assign unused_s = ^sb_load_r;

    // Sequencing FSM: next state, wait counter, sticky error and pipeline controls.
    always_comb begin
        state_n_s    = state_r;
        cnt_n_s      = cnt_r;
        err_n_s      = err_r;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        redirect     = 1'b0;
        if (!enable) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (stall_s) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (issue_s && id_ctrl) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        state_n_s   = CTRL_WAIT;
                        cnt_n_s     = {CNT_W{1'b0}};
                    end else begin
                        pc_en = 1'b1;
                    end
                end
                CTRL_WAIT: begin
                    id_ex_bubble = 1'b1;
                    if (br_resolve) begin
                        redirect  = br_taken;
                        state_n_s = RUN;
                    end else if (cnt_r == TIMEOUT) begin
                        err_n_s   = 1'b1;
                        state_n_s = RUN;
                    end else begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        cnt_n_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    state_n_s = RUN;
                end
            endcase
        end
    end

    // FSM, counter and sticky error registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
        end else if (enable) begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            err_r   <= err_n_s;
        end
    end

    // Scoreboard shift EX->MEM->WB; x0 writes never allocate an entry.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sb_valid_r <= 3'b000;
            sb_waddr_r <= '0;
            sb_load_r  <= 3'b000;
        end else if (enable) begin
            sb_valid_r[2] <= sb_valid_r[1];
            sb_waddr_r[2] <= sb_waddr_r[1];
            sb_load_r[2]  <= sb_load_r[1];
            sb_valid_r[1] <= sb_valid_r[0];
            sb_waddr_r[1] <= sb_waddr_r[0];
            sb_load_r[1]  <= sb_load_r[0];
            sb_valid_r[0] <= issue_s && id_reg_write && (id_waddr != 5'd0);
            sb_waddr_r[0] <= id_waddr;
            sb_load_r[0]  <= id_mem_read;
        end
    end

    assign ctrl_err = err_r;
    assign state    = state_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized + directed bench for hazard_controller against an age-based reference model.
module tb_hazard_controller;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       enable = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_waddr = 5'd0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0, id_ctrl = 1'b0, br_resolve = 1'b0, br_taken = 1'b0;
    logic       pc_en, if_id_en, if_id_flush, id_ex_bubble, redirect, ctrl_err;
    logic [1:0] fwd_a, fwd_b, state;

    hazard_controller #(.RESOLVE_TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .arst(arst), .enable(enable), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_reg_write(id_reg_write), .id_waddr(id_waddr), .id_mem_read(id_mem_read),
        .id_ctrl(id_ctrl), .br_resolve(br_resolve), .br_taken(br_taken),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .redirect(redirect), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ctrl_err(ctrl_err), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: in-flight writers tagged with the enable-cycle they issued in.
    typedef struct {
        logic [4:0] wa;
        logic       ld;
        int         cyc;
    } wr_t;
    wr_t wq[$];
    int  now_cyc = 0;
    bit  m_wait = 0;
    int  m_cnt = 0;
    bit  m_err = 0;

    bit       e_issue, e_pc, e_ifid, e_flush, e_bub, e_redir;
    int       e_fa, e_fb;

    task automatic model_reset();
        wq.delete();
        m_wait = 0;
        m_cnt  = 0;
        m_err  = 0;
    endtask

    task automatic model_eval();
        int  age;
        bit  ma, mb, any, ld_ex, stall;
        e_fa = 0; e_fb = 0; any = 0; ld_ex = 0;
        foreach (wq[i]) begin
            age = now_cyc - wq[i].cyc;
            ma  = id_use_rs && (wq[i].wa == id_rs);
            mb  = id_use_rt && (wq[i].wa == id_rt);
            if (ma || mb) begin
                any = 1;
                if (age == 1 && wq[i].ld) ld_ex = 1;
            end
            if (ma && (e_fa == 0 || age < e_fa)) e_fa = age;
            if (mb && (e_fb == 0 || age < e_fb)) e_fb = age;
        end
`ifdef FORWARDING_EN
        stall = !m_wait && id_valid && ld_ex;
`else
        stall = !m_wait && id_valid && any;
        e_fa = 0;
        e_fb = 0;
`endif
        e_issue = enable && id_valid && !m_wait && !stall;
        e_redir = 0;
        if (!enable) begin
            e_pc = 0; e_ifid = 0; e_flush = 0; e_bub = 0;
        end else if (m_wait) begin
            e_ifid = 1; e_bub = 1;
            if (br_resolve) begin
                e_pc = 1; e_flush = 0; e_redir = br_taken;
            end else if (m_cnt == TIMEOUT) begin
                e_pc = 1; e_flush = 0;
            end else begin
                e_pc = 0; e_flush = 1;
            end
        end else if (stall) begin
            e_pc = 0; e_ifid = 0; e_flush = 0; e_bub = 1;
        end else if (e_issue && id_ctrl) begin
            e_pc = 0; e_ifid = 1; e_flush = 1; e_bub = 0;
        end else begin
            e_pc = 1; e_ifid = 1; e_flush = 0; e_bub = 0;
        end
    endtask

    task automatic model_advance();
        if (!enable) return;
        if (e_issue && id_reg_write && id_waddr != 5'd0)
            wq.push_back('{wa: id_waddr, ld: id_mem_read, cyc: now_cyc});
        now_cyc++;
        while (wq.size() > 0 && now_cyc - wq[0].cyc > 3) void'(wq.pop_front());
        if (m_wait) begin
            if (br_resolve) m_wait = 0;
            else if (m_cnt == TIMEOUT) begin
                m_wait = 0;
                m_err  = 1;
            end else m_cnt++;
        end else if (e_issue && id_ctrl) begin
            m_wait = 1;
            m_cnt  = 0;
        end
    endtask

    // Compare all outputs against the model, then let one clock edge pass.
    task automatic tick();
        #2;
        model_eval();
        check("pc_en", {7'd0, pc_en}, {7'd0, e_pc});
        check("if_id_en", {7'd0, if_id_en}, {7'd0, e_ifid});
        check("if_id_flush", {7'd0, if_id_flush}, {7'd0, e_flush});
        check("id_ex_bubble", {7'd0, id_ex_bubble}, {7'd0, e_bub});
        check("redirect", {7'd0, redirect}, {7'd0, e_redir});
        check("fwd_a", {6'd0, fwd_a}, 8'(e_fa));
        check("fwd_b", {6'd0, fwd_b}, 8'(e_fb));
        check("ctrl_err", {7'd0, ctrl_err}, {7'd0, m_err});
        check("state", {6'd0, state}, {7'd0, m_wait});
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input bit rw, input int wa, input bit ld, input bit ctl);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_reg_write = rw; id_waddr = 5'(wa); id_mem_read = ld; id_ctrl = ctl;
    endtask

    task automatic pulse_reset();
        arst = 1'b1;
        #1;
        model_reset();
        check("rst_state", {6'd0, state}, 8'd0);
        check("rst_ctrl_err", {7'd0, ctrl_err}, 8'd0);
        check("rst_pc_en", {7'd0, pc_en}, {7'd0, enable});
        arst = 1'b0;
        #1;
    endtask

    initial begin
        @(negedge clk);
        enable = 1'b1;
        pulse_reset();
        tick();

        // Producer r5 then dependent reader of r5.
        set_id(1, 1, 2, 0, 0, 1, 5, 0, 0); tick();
        set_id(1, 5, 3, 1, 0, 1, 6, 0, 0);
        repeat (5) tick();
        // Write to r0 then reader of r0.
        set_id(1, 1, 1, 0, 0, 1, 0, 0, 0); tick();
        set_id(1, 0, 0, 1, 1, 0, 0, 0, 0); repeat (2) tick();
        // Load r7 then reader of r7; non-load r9 then rt reader of r9.
        set_id(1, 1, 1, 0, 0, 1, 7, 1, 0); tick();
        set_id(1, 7, 1, 1, 0, 0, 0, 0, 0); repeat (4) tick();
        set_id(1, 1, 1, 0, 0, 1, 9, 0, 0); tick();
        set_id(1, 1, 9, 0, 1, 0, 0, 0, 0); repeat (4) tick();

        // Branch resolved taken three cycles later.
        set_id(1, 1, 2, 0, 0, 0, 0, 0, 1); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) tick();
        br_resolve = 1'b1; br_taken = 1'b1; tick();
        br_resolve = 1'b0; br_taken = 1'b0; tick();

        // Branch never resolved: timeout, then a stray resolve in RUN.
        set_id(1, 1, 2, 0, 0, 0, 0, 0, 1); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (TIMEOUT + 3) tick();
        br_resolve = 1'b1; br_taken = 1'b1; tick();
        br_resolve = 1'b0; br_taken = 1'b0;

        // Reset mid-wait, then an independent instruction must issue.
        set_id(1, 1, 2, 0, 0, 1, 4, 0, 1); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) tick();
        pulse_reset();
        set_id(1, 4, 4, 1, 1, 0, 0, 0, 0); tick();

        // Enable low freezes everything.
        set_id(1, 1, 1, 0, 0, 1, 3, 0, 0); tick();
        enable = 1'b0;
        set_id(1, 3, 3, 1, 1, 0, 0, 0, 0); repeat (3) tick();
        enable = 1'b1; repeat (4) tick();

        // Randomized traffic on a small register range to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            enable       = ($urandom_range(0, 9) != 0);
            id_valid     = ($urandom_range(0, 4) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom);
            id_use_rt    = 1'($urandom);
            id_reg_write = 1'($urandom);
            id_waddr     = 5'($urandom_range(0, 3));
            id_mem_read  = 1'($urandom);
            id_ctrl      = ($urandom_range(0, 9) == 0);
            br_resolve   = ($urandom_range(0, 11) == 0);
            br_taken     = 1'($urandom);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
